act_feeder_row: RTL and testbench

- Activation source for one superblock row array; it is the responder end of the per-row act_data_in / act_data_in_vld / act_data_in_req interface that each sblk consumes.
- Accepts a single upstream stream of activation pairs tagged with a destination row.
- Buffers each row in its own FIFO and returns one word per requested cycle to each row's sblk, registered, one cycle after the request.

---
 rtl/sblk_pkg.sv | 13 +
 rtl/act_fifo.sv | 66 ++++++
 rtl/act_feeder_row.sv | 106 ++++++++++
 tb/tb_act_feeder_row.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_pkg.sv
// Shared definitions for the sblk activation path: word type and row-tag width helper.
package sblk_pkg;

  localparam int WID_ACT      = 16;
  localparam int WID_ACT_WORD = 2 * WID_ACT;

  typedef logic [WID_ACT_WORD-1:0] act_word_t;

  function automatic int row_width(input int n_row);
    return (n_row <= 1) ? 1 : $clog2(n_row);
  endfunction

endpackage

// File: rtl/act_fifo.sv
// Single-clock show-ahead FIFO holding the activation words queued for one sblk row.
module act_fifo #(
  parameter type word_t  = sblk_pkg::act_word_t,
  parameter int  DEPTH   = 16,
  parameter int  WID_CNT = $clog2(DEPTH) + 1
) (
  input  logic               clk_l,
  input  logic               rst_n,
  input  logic               wr_en,
  input  word_t              wr_data,
  input  logic               rd_en,
  output word_t              rd_data,
  output logic               empty,
  output logic               full,
  output logic [WID_CNT-1:0] cnt
);

  localparam int WID_PTR = $clog2(DEPTH);

  word_t              mem_q [DEPTH];
  logic [WID_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [WID_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [WID_CNT-1:0] cnt_q, cnt_d;
  logic               do_wr, do_rd;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == WID_CNT'(DEPTH));
  assign cnt     = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers are exactly log2(DEPTH) wide, so the increment wraps on its own.
    if (do_wr) wr_ptr_d = wr_ptr_q + WID_PTR'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + WID_PTR'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + WID_CNT'(1);
      2'b01:   cnt_d = cnt_q - WID_CNT'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the payload array is deliberately not reset; cnt_q alone decides which entries are live.
  always_ff @(posedge clk_l) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/act_feeder_row.sv
// Per-row activation feeder for one sblk row array: routes tagged upstream words into row FIFOs
// and answers each row's level-sensitive request with one registered word. Optional: ACT_FEEDER_BCAST_EN.
module act_feeder_row #(
  parameter int N_ROW      = 7,
  parameter int WID_ACT    = sblk_pkg::WID_ACT,
  parameter int FIFO_DEPTH = 16,
  parameter int WID_ROW    = sblk_pkg::row_width(N_ROW),
  parameter int WID_CNT    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk_l,
  input  logic                       rst_n,
  input  logic [2*WID_ACT-1:0]       ld_data,
  input  logic [WID_ROW-1:0]         ld_row,
  input  logic                       ld_vld,
`ifdef ACT_FEEDER_BCAST_EN
  input  logic                       ld_bcast,
`endif
  output logic                       ld_rdy,
  output logic [2*WID_ACT*N_ROW-1:0] act_data_out,
  output logic [N_ROW-1:0]           act_data_out_vld,
  input  logic [N_ROW-1:0]           act_data_out_req,
  output logic [N_ROW-1:0]           act_empty,
  output logic                       err_bad_row
);

  localparam int WID_WORD = 2 * WID_ACT;
  typedef logic [WID_WORD-1:0] word_t;

  word_t              head [N_ROW];
  logic [WID_CNT-1:0] cnt  [N_ROW];
  logic [N_ROW-1:0]   full, empty, wr_en, rd;
  logic               row_ok, bcast, xfer;

  word_t              data_q [N_ROW];
  word_t              data_d [N_ROW];
  logic [N_ROW-1:0]   vld_q, vld_d;
  logic               err_q, err_d;

`ifdef ACT_FEEDER_BCAST_EN
  assign bcast = ld_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign row_ok = (32'(ld_row) < N_ROW);

  // ld_rdy looks only at the tag and registered occupancy, never at ld_vld.
  always_comb begin
    ld_rdy = 1'b1;
    if (bcast) begin
      ld_rdy = !(|full);
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (row_ok && (ld_row == WID_ROW'(r))) ld_rdy = !full[r];
      end
    end
  end

  always_comb begin
    xfer  = ld_vld && ld_rdy;
    err_d = err_q || (xfer && !bcast && !row_ok);
    for (int r = 0; r < N_ROW; r++) begin
      wr_en[r]     = xfer && (bcast || (row_ok && (ld_row == WID_ROW'(r))));
      rd[r]        = act_data_out_req[r] && !empty[r];
      act_empty[r] = (cnt[r] == '0);
      data_d[r]    = rd[r] ? head[r] : data_q[r];
    end
    vld_d = rd;
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= 1'b0;
      for (int r = 0; r < N_ROW; r++) data_q[r] <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      for (int r = 0; r < N_ROW; r++) data_q[r] <= data_d[r];
    end
  end

  assign act_data_out_vld = vld_q;
  assign err_bad_row      = err_q;

  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    act_fifo #(
      .word_t  (word_t),
      .DEPTH   (FIFO_DEPTH),
      .WID_CNT (WID_CNT)
    ) u_fifo (
      .clk_l   (clk_l),
      .rst_n   (rst_n),
      .wr_en   (wr_en[r]),
      .wr_data (ld_data),
      .rd_en   (rd[r]),
      .rd_data (head[r]),
      .empty   (empty[r]),
      .full    (full[r]),
      .cnt     (cnt[r])
    );

    assign act_data_out[r*WID_WORD +: WID_WORD] = data_q[r];
  end

endmodule

// File: tb/tb_act_feeder_row.sv
// Directed bench for act_feeder_row with a per-row scoreboard checked whenever a row asserts vld.
`timescale 1ns/1ps
module tb_act_feeder_row;
  import sblk_pkg::*;

  localparam int N_ROW = 7;
  localparam int W     = WID_ACT_WORD;

  logic               clk_l = 1'b0;
  logic               rst_n = 1'b0;
  act_word_t          ld_data = '0;
  logic [2:0]         ld_row = '0;
  logic               ld_vld = 1'b0;
  logic               ld_rdy;
  logic [W*N_ROW-1:0] act_data_out;
  logic [N_ROW-1:0]   act_data_out_vld;
  logic [N_ROW-1:0]   act_data_out_req = '0;
  logic [N_ROW-1:0]   act_empty;
  logic               err_bad_row;
`ifdef ACT_FEEDER_BCAST_EN
  logic               ld_bcast = 1'b0;
`endif

  act_word_t exp_q [N_ROW][$];
  int total = 0;
  int bad   = 0;

  always #5 clk_l = ~clk_l;

  act_feeder_row dut (
    .clk_l            (clk_l),
    .rst_n            (rst_n),
    .ld_data          (ld_data),
    .ld_row           (ld_row),
    .ld_vld           (ld_vld),
`ifdef ACT_FEEDER_BCAST_EN
    .ld_bcast         (ld_bcast),
`endif
    .ld_rdy           (ld_rdy),
    .act_data_out     (act_data_out),
    .act_data_out_vld (act_data_out_vld),
    .act_data_out_req (act_data_out_req),
    .act_empty        (act_empty),
    .err_bad_row      (err_bad_row)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic act_word_t slice(input int r);
    return act_data_out[r*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  // Drives one upstream word; only in-range rows expect it back.
  task automatic load(input int row, input act_word_t d);
    ld_row  = 3'(row);
    ld_data = d;
    ld_vld  = 1'b1;
    if (row < N_ROW) exp_q[row].push_back(d);
  endtask

  always @(negedge clk_l) begin
    for (int r = 0; r < N_ROW; r++) begin
      if (act_data_out_vld[r]) begin
        if (exp_q[r].size() == 0) begin
          check($sformatf("row%0d_spurious_vld", r), 64'(act_data_out_vld[r]), 64'd0);
        end else begin
          check($sformatf("row%0d_data", r), 64'(slice(r)), 64'(exp_q[r].pop_front()));
        end
      end
    end
  end

  initial begin
    int n;

    #3;
    check("rst_vld", 64'(act_data_out_vld), 64'd0);
    check("rst_data_nonzero", 64'(|act_data_out), 64'd0);
    check("rst_err", 64'(err_bad_row), 64'd0);
    check("rst_empty", 64'(act_empty), 64'h7F);
    check("rst_rdy", 64'(ld_rdy), 64'd1);
    #10 rst_n = 1'b1;
    tick();

    // Single word to row 3 with the request already high.
    load(3, 32'h0001_0002);
    act_data_out_req[3] = 1'b1;
    tick();
    ld_vld = 1'b0;
    check("t1_vld_early", 64'(act_data_out_vld), 64'd0);
    check("t1_not_empty", 64'(act_empty[3]), 64'd0);
    tick();
    check("t1_vld", 64'(act_data_out_vld), 64'h08);
    check("t1_slice", 64'(slice(3)), 64'h0001_0002);
    check("t1_empty_again", 64'(act_empty[3]), 64'd1);
    tick();
    check("t1_vld_off", 64'(act_data_out_vld[3]), 64'd0);
    check("t1_slice_hold", 64'(slice(3)), 64'h0001_0002);
    act_data_out_req[3] = 1'b0;

    // Request on an empty row, then a late write.
    act_data_out_req[5] = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (act_data_out_vld[5]) n++;
    end
    check("t5_idle_vld", 64'(n), 64'd0);
    check("t5_idle_err", 64'(err_bad_row), 64'd0);
    load(5, 32'h5555_0005);
    tick();
    ld_vld = 1'b0;
    check("t5_vld_early", 64'(act_data_out_vld[5]), 64'd0);
    tick();
    check("t5_vld", 64'(act_data_out_vld[5]), 64'd1);
    act_data_out_req[5] = 1'b0;
    tick();

    // Fill row 0, confirm backpressure is per row, then drain back-to-back.
    for (int i = 0; i < 16; i++) begin
      load(0, 32'(i));
      #1 check($sformatf("t2_rdy_%0d", i), 64'(ld_rdy), 64'd1);
      tick();
    end
    ld_vld = 1'b0;
    ld_row = 3'd0;
    #1 check("t2_full_rdy", 64'(ld_rdy), 64'd0);
    ld_row = 3'd1;
    #1 check("t2_other_rdy", 64'(ld_rdy), 64'd1);
    ld_row  = 3'd0;
    ld_data = 32'h0000_0BAD;
    ld_vld  = 1'b1;
    tick();
    ld_vld = 1'b0;
    act_data_out_req[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      check($sformatf("t2_drain_vld_%0d", i), 64'(act_data_out_vld[0]), 64'(i < 16));
    end
    act_data_out_req[0] = 1'b0;
    check("t2_empty", 64'(act_empty[0]), 64'd1);

    // Row 2: simultaneous write and read keep occupancy at 4.
    for (int i = 0; i < 4; i++) begin
      load(2, 32'h2000_0000 + 32'(i));
      tick();
    end
    load(2, 32'h2000_0004);
    act_data_out_req[2] = 1'b1;
    tick();
    ld_vld = 1'b0;
    n = act_data_out_vld[2] ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (act_data_out_vld[2]) n++;
    end
    act_data_out_req[2] = 1'b0;
    check("t3_word_count", 64'(n), 64'd5);
    check("t3_empty", 64'(act_empty[2]), 64'd1);

    // Out-of-range row tag.
    load(7, 32'h0000_DEAD);
    #1 check("t4_rdy", 64'(ld_rdy), 64'd1);
    tick();
    ld_vld = 1'b0;
    check("t4_err_set", 64'(err_bad_row), 64'd1);
    act_data_out_req = '1;
    tick();
    tick();
    tick();
    act_data_out_req = '0;
    check("t4_err_sticky", 64'(err_bad_row), 64'd1);
    check("t4_fifos_unchanged", 64'(act_empty), 64'h7F);

    // Reset in the middle of a drain of row 1.
    for (int i = 0; i < 8; i++) begin
      load(1, 32'h1000_0000 + 32'(i));
      tick();
    end
    ld_vld = 1'b0;
    act_data_out_req[1] = 1'b1;
    tick();
    tick();
    tick();
    check("t6_draining", 64'(act_data_out_vld[1]), 64'd1);
    #2 rst_n = 1'b0;
    exp_q[1].delete();
    #1 check("t6_vld_async", 64'(act_data_out_vld), 64'd0);
    check("t6_empty_async", 64'(act_empty), 64'h7F);
    check("t6_err_clr", 64'(err_bad_row), 64'd0);
    @(posedge clk_l);
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (act_data_out_vld[1]) n++;
    end
    act_data_out_req[1] = 1'b0;
    check("t6_no_vld_after", 64'(n), 64'd0);
    check("t6_empty_after", 64'(act_empty), 64'h7F);

`ifdef ACT_FEEDER_BCAST_EN
    // Broadcast ignores the tag, even an out-of-range one.
    act_data_out_req = '1;
    ld_row   = 3'd7;
    ld_data  = 32'hAAAA_5555;
    ld_bcast = 1'b1;
    ld_vld   = 1'b1;
    for (int r = 0; r < N_ROW; r++) exp_q[r].push_back(32'hAAAA_5555);
    #1 check("bc_rdy", 64'(ld_rdy), 64'd1);
    tick();
    ld_vld   = 1'b0;
    ld_bcast = 1'b0;
    check("bc_vld_early", 64'(act_data_out_vld), 64'd0);
    tick();
    check("bc_vld_all", 64'(act_data_out_vld), 64'h7F);
    check("bc_err", 64'(err_bad_row), 64'd0);
    tick();
    check("bc_vld_off", 64'(act_data_out_vld), 64'd0);
    act_data_out_req = '0;
`endif

    tick();
    n = 0;
    for (int r = 0; r < N_ROW; r++) n += exp_q[r].size();
    check("sb_leftover", 64'(n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
